// File: rtl/sync_bank_pkg.sv
// Shared definitions for the sync_bank CDC input bank: legality limits,
// counter sizing and the per-channel output bundle.
package sync_bank_pkg;

   localparam int unsigned MinStages       = 2;
   localparam int unsigned MinFilterCycles = 1;

   // Level plus its one-cycle edge events, as produced by one channel
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } chan_out_t;

   // The counter must hold 0..FilterCycles-1; never narrower than one bit
   function automatic int unsigned cnt_width(int unsigned filter_cycles);
      int unsigned w;
      w = $clog2(filter_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_bank_chan.sv
// One sync_bank channel: flop synchronizer, optional debounce filter and edge
// pulses. The filter is built only when COMMON_CELLS_SYNC_BANK_FILTER_EN is defined.
module sync_bank_chan
   import sync_bank_pkg::*;
#(
   parameter int unsigned Stages       = 2,
   parameter logic        ResetValue   = 1'b0,
   parameter int unsigned FilterCycles = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      serial_i,
   output chan_out_t chan_o
);

   if (Stages < MinStages) begin : gen_bad_stages
      $fatal(1, "sync_bank_chan: Stages must be at least 2");
   end
   if (FilterCycles < MinFilterCycles) begin : gen_bad_filter
      $fatal(1, "sync_bank_chan: FilterCycles must be at least 1");
   end

   (* async_reg = "true", dont_touch = "true" *) logic [Stages-1:0] sync_q;
   logic sync;
   logic filt_q;
   logic filt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {Stages{ResetValue}};
      end else begin
         sync_q <= {sync_q[Stages-2:0], serial_i};
      end
   end

   assign sync = sync_q[Stages-1];

`ifdef COMMON_CELLS_SYNC_BANK_FILTER_EN
   localparam int unsigned CntW = cnt_width(FilterCycles);
   localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

   logic [CntW-1:0] cnt_q;

   // Any return to the accepted level discards the partial count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         filt_q <= ResetValue;
         cnt_q  <= '0;
      end else if (sync == filt_q) begin
         cnt_q  <= '0;
      end else if (cnt_q == CntMax) begin
         filt_q <= sync;
         cnt_q  <= '0;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end
`else
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         filt_q <= ResetValue;
      end else begin
         filt_q <= sync;
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         filt_d <= ResetValue;
      end else begin
         filt_d <= filt_q;
      end
   end

   assign chan_o.level = filt_q;
   assign chan_o.rise  = filt_q & ~filt_d;
   assign chan_o.fall  = ~filt_q & filt_d;

endmodule

// File: rtl/sync_bank.sv
// Multi-channel CDC input bank: Width independent sync_bank_chan instances.
// Debounce filtering is enabled by defining COMMON_CELLS_SYNC_BANK_FILTER_EN.
module sync_bank
   import sync_bank_pkg::*;
#(
   parameter int unsigned      Width        = 1,
   parameter int unsigned      Stages       = 2,
   parameter logic [Width-1:0] ResetValue   = '0,
   parameter int unsigned      FilterCycles = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] serial_i,
   output logic [Width-1:0] serial_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o
);

   for (genvar c = 0; c < Width; c++) begin : gen_chan
      chan_out_t chan_out;

      sync_bank_chan #(
         .Stages       (Stages),
         .ResetValue   (ResetValue[c]),
         .FilterCycles (FilterCycles)
      ) u_chan (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .serial_i (serial_i[c]),
         .chan_o   (chan_out)
      );

      assign serial_o[c] = chan_out.level;
      assign rise_o[c]   = chan_out.rise;
      assign fall_o[c]   = chan_out.fall;
   end

endmodule
